snake_body: RTL and testbench
=============================

SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 Parameter MOVE_DIV, default 4_000_000, vga_clk cycles per move tick (10 moves/s at 40 MHz).
REQ-002 Parameter MAX_LEN, default 16, maximum segment count.
REQ-003 Parameter INIT_LEN, default 3, segment count after reset/restart.
REQ-004 Parameter CELL, default 10, cell edge in pixels; grid 80x60 cells over 800x600.
REQ-005 vga_clk  in  1  clock; all logic rising-edge.
REQ-006 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-007 key_up, key_down, key_left, key_right  in  1 each  debounced single-cycle direction pulses.
REQ-008 key_start  in  1  debounced single-cycle start/restart pulse.
REQ-009 pixel_xpos, pixel_ypos  in  11 each  current scan pixel from VGA driver.
REQ-010 box_x, box_y  in  10 each  food pixel origin, multiple of CELL.
REQ-011 snack_r  out  1  current pixel lies inside a live snake segment.
REQ-012 fin  out  1  game over; feeds display fin.
REQ-013 eat  out  1  one-cycle pulse when head enters food cell.
REQ-014 snake_len  out  5  live segment count.
REQ-015 head_x  out  7, head_y  out  6  head cell coordinates.

Function
REQ-016 State machine IDLE, RUN, DEAD; reset enters IDLE.
REQ-017 IDLE: snake held at initial position; key_start or any direction key -> RUN, move counter cleared.
REQ-018 Move counter counts 0..MOVE_DIV-1 in RUN only; tick asserted at MOVE_DIV-1, then wraps to 0.
REQ-019 Direction keys latch pending direction any cycle in IDLE/RUN; priority up>down>left>right when simultaneous.
REQ-020 Pending direction exactly opposite current direction is discarded.
REQ-021 On tick, current direction <= pending; new head = head +/-1 in that direction; segment[i] <= segment[i-1] for i=1..MAX_LEN-1.
REQ-022 Wall collision: new head x<0, x>79, y<0 or y>59 -> DEAD, segments unchanged.
REQ-023 Self collision: new head equals any live segment index 1..snake_len-2 -> DEAD, segments unchanged.
REQ-024 Eat: new head*CELL equals (box_x, box_y) with no collision -> eat=1 for one cycle, snake_len+1 saturating at MAX_LEN.
REQ-025 Collision and eat on same tick: collision wins, eat stays 0.
REQ-026 fin = 1 exactly while in DEAD.
REQ-027 DEAD: direction keys ignored; key_start -> IDLE with initial snake restored.
REQ-028 snack_r registered, valid one cycle after pixel_xpos/ypos: 1 if any segment i<snake_len satisfies x*CELL <= pixel_xpos < x*CELL+CELL and same for y.
REQ-029 Segment pixel origin computed as (x<<3)+(x<<1); no dividers.
REQ-030 snack_r = 0 when pixel_xpos >= 800 or pixel_ypos >= 600.
REQ-031 Segments with index >= snake_len never drive snack_r and never collide.

Reset
REQ-032 Reset: state IDLE, counter 0, direction RIGHT, pending RIGHT.
REQ-033 Reset: snake_len=INIT_LEN, segment[0]=(40,30), segment[1]=(39,30), segment[2]=(38,30), others (0,0).
REQ-034 Reset: snack_r=0, fin=0, eat=0, head_x=40, head_y=30.
REQ-035 Reset asserted mid-RUN or mid-DEAD returns to reset values immediately, no tick completion.

Structure
REQ-036 Shared package snake_pkg holds direction encoding (UP, DOWN, LEFT, RIGHT), state encoding, grid constants 80/60, CELL.
REQ-037 One sub-module seg_hit: combinational compare of one segment against pixel position; instantiated MAX_LEN times, outputs ORed then registered.

Verification
REQ-038 Reset, key_start, MOVE_DIV=4, run 3 ticks -> head (43,30), snake_len 3, fin 0.
REQ-039 Head (40,30) moving RIGHT, key_left then key_up same cycle -> up applied, next tick head (40,29); key_left alone -> discarded, head (41,30).
REQ-040 Head at (79,30) moving RIGHT, tick -> fin=1 next cycle, head stays (79,30); key_start -> IDLE, head (40,30), fin 0.
REQ-041 box=(410,300), head (40,30) RIGHT, tick -> eat pulse 1 cycle, snake_len 4; at snake_len 16 repeat -> eat pulse, snake_len stays 16.
REQ-042 Initial snake, pixel (385,305) -> snack_r=1 one cycle later; pixel (410,305) -> 0; pixel (380,299) -> 0.
REQ-043 Length-5 snake driven into own segment 3 -> DEAD; driven into tail cell (index 4) -> no collision.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game body logic.
// Directions, game states, grid geometry and the cell-to-pixel helper.
package snake_pkg;

   typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
   typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

   typedef struct packed {
      logic [6:0] x;
      logic [5:0] y;
   } seg_t;

   localparam int GRID_W  = 80;
   localparam int GRID_H  = 60;
   localparam int CELL_PX = 10;
   localparam int SCR_W   = GRID_W * CELL_PX;
   localparam int SCR_H   = GRID_H * CELL_PX;
   localparam int START_X = 40;
   localparam int START_Y = 30;

   // Cell index to pixel origin for 10-pixel cells: c*8 + c*2, no multiplier.
   function automatic logic [10:0] cell_origin(input logic [6:0] c);
      logic [10:0] w;
      w = {4'b0, c};
      return (w << 3) + (w << 1);
   endfunction

   function automatic dir_t opposite(input dir_t d);
      unique case (d)
         UP:      return DOWN;
         DOWN:    return UP;
         LEFT:    return RIGHT;
         default: return LEFT;
      endcase
   endfunction

endpackage

// File: rtl/snake_if.sv
// Bundle between the game controller/VGA side and the snake body:
// key pulses, scan position and food in; draw/status results out.
interface snake_if;

   logic        key_up;
   logic        key_down;
   logic        key_left;
   logic        key_right;
   logic        key_start;
   logic [10:0] pixel_xpos;
   logic [10:0] pixel_ypos;
   logic [9:0]  box_x;
   logic [9:0]  box_y;
   logic        snack_r;
   logic        fin;
   logic        eat;
   logic [4:0]  snake_len;
   logic [6:0]  head_x;
   logic [5:0]  head_y;

   modport master (
      output key_up, key_down, key_left, key_right, key_start,
      output pixel_xpos, pixel_ypos, box_x, box_y,
      input  snack_r, fin, eat, snake_len, head_x, head_y
   );

   modport slave (
      input  key_up, key_down, key_left, key_right, key_start,
      input  pixel_xpos, pixel_ypos, box_x, box_y,
      output snack_r, fin, eat, snake_len, head_x, head_y
   );

endinterface

// File: rtl/seg_hit.sv
// Combinational test of whether the scan pixel falls inside one live segment cell.
module seg_hit
   import snake_pkg::*;
#(
   parameter int CELL = 10
) (
   input  logic [6:0]  seg_x,
   input  logic [5:0]  seg_y,
   input  logic        live,
   input  logic [10:0] pixel_xpos,
   input  logic [10:0] pixel_ypos,
   output logic        hit
);

   logic [10:0] org_x;
   logic [10:0] org_y;

   assign org_x = cell_origin(seg_x);
   assign org_y = cell_origin({1'b0, seg_y});

   assign hit = live
              && (pixel_xpos >= org_x) && (pixel_xpos < org_x + 11'(CELL))
              && (pixel_ypos >= org_y) && (pixel_ypos < org_y + 11'(CELL));

endmodule

// File: rtl/snake_body.sv
// Snake body: move timing, steering, growth, collisions and per-pixel body
// rendering on the 80x60 cell grid.
module snake_body
   import snake_pkg::*;
#(
   parameter int MOVE_DIV = 4_000_000,
   parameter int MAX_LEN  = 16,
   parameter int INIT_LEN = 3,
   parameter int CELL     = 10
) (
   input logic   vga_clk,
   input logic   sys_rst_n,
   snake_if.slave bus
);

   localparam int              CNT_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);
   localparam logic [4:0]      LEN_INIT = 5'(INIT_LEN);
   localparam logic [4:0]      LEN_MAX  = 5'(MAX_LEN);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   move_cnt;
   dir_t               cur_dir, pend_dir, key_dir;
   seg_t               seg [MAX_LEN];
   seg_t               nh;
   logic [4:0]         len;
   logic               eat_r, snack_q;
   logic               any_key, accept_key, restart, tick;
   logic               wall_hit, self_hit, food_hit, collide;
   logic [MAX_LEN-1:0] hits;

   function automatic seg_t init_seg(input int i);
      seg_t s;
      s = '0;
      if (i < INIT_LEN) begin
         s.x = 7'(START_X - i);
         s.y = 6'(START_Y);
      end
      return s;
   endfunction

   assign any_key    = bus.key_up | bus.key_down | bus.key_left | bus.key_right;
   assign key_dir    = bus.key_up ? UP : bus.key_down ? DOWN : bus.key_left ? LEFT : RIGHT;
   assign accept_key = any_key && (state != DEAD) && (key_dir != opposite(cur_dir));
   assign restart    = (state == DEAD) && bus.key_start;
   assign tick       = (state == RUN) && (move_cnt == CNT_LAST);

   // NOTE: combinational blocks assign every output a default first so no path leaves a latch.
   always_comb begin
      nh       = seg[0];
      wall_hit = 1'b0;
      unique case (pend_dir)
         UP:    if (seg[0].y == '0)               wall_hit = 1'b1; else nh.y = seg[0].y - 6'd1;
         DOWN:  if (seg[0].y == 6'(GRID_H - 1))   wall_hit = 1'b1; else nh.y = seg[0].y + 6'd1;
         LEFT:  if (seg[0].x == '0)               wall_hit = 1'b1; else nh.x = seg[0].x - 7'd1;
         RIGHT: if (seg[0].x == 7'(GRID_W - 1))   wall_hit = 1'b1; else nh.x = seg[0].x + 7'd1;
      endcase
   end

   // The tail (index len-1) vacates its cell on this move, so it cannot be hit.
   always_comb begin
      self_hit = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         if ((i + 2 <= int'(len)) && (seg[i] == nh)) self_hit = 1'b1;
      end
   end

   assign collide  = wall_hit | self_hit;
   assign food_hit = (cell_origin(nh.x) == {1'b0, bus.box_x})
                  && (cell_origin({1'b0, nh.y}) == {1'b0, bus.box_y});

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.key_start || any_key) state_nxt = RUN;
         RUN:     if (tick && collide)          state_nxt = DEAD;
         DEAD:    if (bus.key_start)            state_nxt = IDLE;
         default:                               state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_nxt;
   end

   // NOTE: the segment array is reset explicitly because the initial snake is game-visible state.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         move_cnt <= '0;
         cur_dir  <= RIGHT;
         pend_dir <= RIGHT;
         len      <= LEN_INIT;
         eat_r    <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_seg(i);
      end else begin
         eat_r <= tick && !collide && food_hit;

         if (state != RUN || tick) move_cnt <= '0;
         else                      move_cnt <= move_cnt + 1'b1;

         if (restart)         pend_dir <= RIGHT;
         else if (accept_key) pend_dir <= key_dir;

         if (restart)   cur_dir <= RIGHT;
         else if (tick) cur_dir <= pend_dir;

         if (restart) begin
            len <= LEN_INIT;
            for (int i = 0; i < MAX_LEN; i++) seg[i] <= init_seg(i);
         end else if (tick && !collide) begin
            if (food_hit && len < LEN_MAX) len <= len + 5'd1;
            seg[0] <= nh;
            for (int i = 1; i < MAX_LEN; i++) seg[i] <= seg[i-1];
         end
      end
   end

   for (genvar g = 0; g < MAX_LEN; g++) begin : g_hit
      seg_hit #(.CELL(CELL)) u_seg_hit (
         .seg_x      (seg[g].x),
         .seg_y      (seg[g].y),
         .live       (5'(g) < len),
         .pixel_xpos (bus.pixel_xpos),
         .pixel_ypos (bus.pixel_ypos),
         .hit        (hits[g])
      );
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) snack_q <= 1'b0;
      else            snack_q <= (|hits) && (bus.pixel_xpos < 11'(SCR_W))
                                         && (bus.pixel_ypos < 11'(SCR_H));
   end

   assign bus.snack_r   = snack_q;
   assign bus.fin       = (state == DEAD);
   assign bus.eat       = eat_r;
   assign bus.snake_len = len;
   assign bus.head_x    = seg[0].x;
   assign bus.head_y    = seg[0].y;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body with a 4-cycle move period.
module tb_snake_body;
   import snake_pkg::*;

   logic vga_clk   = 1'b0;
   logic sys_rst_n = 1'b0;
   int   checks    = 0;
   int   failures  = 0;

   snake_if bus ();

   snake_body #(
      .MOVE_DIV (4),
      .MAX_LEN  (16),
      .INIT_LEN (3),
      .CELL     (10)
   ) dut (
      .vga_clk   (vga_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge vga_clk);
   endtask

   task automatic pulse(input logic u, input logic d, input logic l, input logic r, input logic s);
      bus.key_up = u; bus.key_down = d; bus.key_left = l; bus.key_right = r; bus.key_start = s;
      @(negedge vga_clk);
      bus.key_up = 0; bus.key_down = 0; bus.key_left = 0; bus.key_right = 0; bus.key_start = 0;
   endtask

   task automatic apply_reset();
      sys_rst_n = 1'b0;
      @(negedge vga_clk);
      sys_rst_n = 1'b1;
      @(negedge vga_clk);
   endtask

   task automatic check_head(input string tag, input int x, input int y);
      check({tag, "_x"}, 32'(bus.head_x), 32'(x));
      check({tag, "_y"}, 32'(bus.head_y), 32'(y));
   endtask

   task automatic check_pixel(input string tag, input int px, input int py, input logic exp);
      bus.pixel_xpos = 11'(px);
      bus.pixel_ypos = 11'(py);
      @(negedge vga_clk);
      check(tag, 32'(bus.snack_r), 32'(exp));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      bus.key_up = 0; bus.key_down = 0; bus.key_left = 0; bus.key_right = 0; bus.key_start = 0;
      bus.pixel_xpos = '0; bus.pixel_ypos = '0;
      bus.box_x = '0; bus.box_y = '0;

      // reset values
      cycles(2);
      check_head("rst_head", 40, 30);
      check("rst_len", 32'(bus.snake_len), 32'd3);
      check("rst_fin", 32'(bus.fin), 32'd0);
      check("rst_eat", 32'(bus.eat), 32'd0);
      check("rst_snack", 32'(bus.snack_r), 32'd0);
      sys_rst_n = 1'b1;
      cycles(8);
      check_head("idle_hold", 40, 30);

      // three moves after start
      pulse(0, 0, 0, 0, 1);
      cycles(12);
      check_head("run3", 43, 30);
      check("run3_len", 32'(bus.snake_len), 32'd3);
      check("run3_fin", 32'(bus.fin), 32'd0);

      // asynchronous reset mid-run
      sys_rst_n = 1'b0;
      #1;
      check_head("async_rst", 40, 30);
      @(negedge vga_clk);
      sys_rst_n = 1'b1;
      @(negedge vga_clk);

      // simultaneous left+up: up wins; then down (opposite of up) is discarded
      pulse(0, 0, 0, 0, 1);
      pulse(1, 0, 1, 0, 0);
      cycles(3);
      check_head("prio_up", 40, 29);
      pulse(0, 1, 0, 0, 0);
      cycles(3);
      check_head("opp_down", 40, 28);

      // left while moving right is discarded
      apply_reset();
      pulse(0, 0, 0, 0, 1);
      pulse(0, 0, 1, 0, 0);
      cycles(3);
      check_head("opp_left", 41, 30);

      // right wall
      cycles(4 * 38);
      check_head("wall_edge", 79, 30);
      check("wall_edge_fin", 32'(bus.fin), 32'd0);
      cycles(4);
      check("wall_fin", 32'(bus.fin), 32'd1);
      check_head("wall_hold", 79, 30);
      pulse(1, 0, 0, 0, 0);
      cycles(7);
      check_head("dead_keys", 79, 30);
      check("dead_fin", 32'(bus.fin), 32'd1);
      pulse(0, 0, 0, 0, 1);
      check("restart_fin", 32'(bus.fin), 32'd0);
      check("restart_len", 32'(bus.snake_len), 32'd3);
      check_head("restart", 40, 30);
      cycles(8);
      check_head("restart_idle", 40, 30);

      // eating and saturation at 16
      bus.box_x = 10'd410; bus.box_y = 10'd300;
      pulse(0, 0, 0, 0, 1);
      cycles(3);
      check("eat_pre", 32'(bus.eat), 32'd0);
      cycles(1);
      check("eat1", 32'(bus.eat), 32'd1);
      check("eat1_len", 32'(bus.snake_len), 32'd4);
      bus.box_x = 10'd420;
      cycles(1);
      check("eat1_pulse_end", 32'(bus.eat), 32'd0);
      cycles(3);
      check("grow_len5", 32'(bus.snake_len), 32'd5);
      for (int k = 1; k <= 11; k++) begin
         bus.box_x = 10'((42 + k) * 10);
         cycles(4);
         check("grow_len", 32'(bus.snake_len), 32'(5 + k));
      end
      check_head("grow_head", 53, 30);
      bus.box_x = 10'd540;
      cycles(3);
      check("sat_pre", 32'(bus.eat), 32'd0);
      cycles(1);
      check("sat_eat", 32'(bus.eat), 32'd1);
      check("sat_len", 32'(bus.snake_len), 32'd16);
      check_head("sat_head", 54, 30);
      cycles(1);
      check("sat_pulse_end", 32'(bus.eat), 32'd0);

      // body rendering on the initial snake
      apply_reset();
      bus.box_x = '0; bus.box_y = '0;
      bus.pixel_xpos = 11'd385; bus.pixel_ypos = 11'd305;
      #1;
      check("pix_latency", 32'(bus.snack_r), 32'd0);
      @(negedge vga_clk);
      check("pix_385_305", 32'(bus.snack_r), 32'd1);
      check_pixel("pix_410_305", 410, 305, 1'b0);
      check_pixel("pix_380_299", 380, 299, 1'b0);
      check_pixel("pix_head", 400, 300, 1'b1);
      check_pixel("pix_seg1_corner", 399, 309, 1'b1);
      check_pixel("pix_dead_seg", 5, 5, 1'b0);
      check_pixel("pix_410_300", 410, 300, 1'b0);

      // tail chasing at length 4, then self collision at length 5
      apply_reset();
      bus.box_x = 10'd410; bus.box_y = 10'd300;
      pulse(0, 0, 0, 0, 1);
      cycles(4);
      check("loop_len4", 32'(bus.snake_len), 32'd4);
      bus.box_x = '0; bus.box_y = '0;
      pulse(1, 0, 0, 0, 0); cycles(3);
      check_head("loop_up", 41, 29);
      pulse(0, 0, 1, 0, 0); cycles(3);
      check_head("loop_left", 40, 29);
      pulse(0, 1, 0, 0, 0); cycles(3);
      check_head("tail_down", 40, 30);
      check("tail_down_fin", 32'(bus.fin), 32'd0);
      pulse(0, 0, 0, 1, 0); cycles(3);
      check_head("tail_right", 41, 30);
      check("tail_right_fin", 32'(bus.fin), 32'd0);
      bus.box_x = 10'd420; bus.box_y = 10'd300;
      cycles(4);
      check("self_len5", 32'(bus.snake_len), 32'd5);
      bus.box_x = '0; bus.box_y = '0;
      pulse(1, 0, 0, 0, 0); cycles(3);
      check_head("self_up", 42, 29);
      pulse(0, 0, 1, 0, 0); cycles(3);
      check_head("self_left", 41, 29);
      check("self_left_fin", 32'(bus.fin), 32'd0);
      pulse(0, 1, 0, 0, 0); cycles(3);
      check("self_fin", 32'(bus.fin), 32'd1);
      check_head("self_hold", 41, 29);
      check("self_len_hold", 32'(bus.snake_len), 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
